id_ctrl_stage: RTL and testbench

- Registered instruction-decode control stage for the pipelined MIPS core.
- Decodes opcode/funct into EX/MEM/WB control buses and registers them into the ID/EX control slice.
- Detects load-use hazards, injects bubbles on stall or flush, and handles a HALT instruction with a counted pipeline drain.
- Sits between the IF/ID register and the ID/EX datapath register; drives the fetch stall line.

---
 rtl/id_ctrl_pkg.sv | 69 ++++++
 rtl/id_ctrl_stage_decode.sv | 97 +++++++++
 rtl/id_ctrl_stage.sv | 153 +++++++++++++++
 tb/tb_id_ctrl_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// Shared constants for the ID control stage: bus bit positions, ALU op codes, opcodes/functs, FSM states.
// Combinational constants only; no latency or flow control.
package id_ctrl_pkg;

  localparam int EXEC_W = 7;
  localparam int MEM_W  = 3;
  localparam int WB_W   = 2;
  localparam int RA_W   = 5;

  localparam int EX_ALU_SRC  = 4;
  localparam int EX_REG_DST  = 5;
  localparam int EX_SHAMT    = 6;
  localparam int MEM_WRITE   = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_BRANCH  = 2;
  localparam int WB_MEM2REG  = 0;
  localparam int WB_REGWRITE = 1;

  typedef enum logic [3:0] {
    ALU_SLL     = 4'd0,
    ALU_SRL     = 4'd1,
    ALU_SRA     = 4'd2,
    ALU_ADD     = 4'd3,
    ALU_AND     = 4'd4,
    ALU_OR      = 4'd5,
    ALU_XOR     = 4'd6,
    ALU_NOR     = 4'd7,
    ALU_SUB     = 4'd8,
    ALU_SLT     = 4'd9,
    ALU_INVALID = 4'd15
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/id_ctrl_stage_decode.sv
// Pure opcode/funct decode into EX/MEM/WB control buses plus operand-use and HALT flags.
// Zero latency; no flow control of its own.
module ctrl_decode
  import id_ctrl_pkg::*;
#(
  parameter int EXEC_BUS_WIDTH = EXEC_W,
  parameter int MEM_BUS_WIDTH  = MEM_W,
  parameter int WB_BUS_WIDTH   = WB_W
) (
  input  logic [31:0]               instr,
  output logic [EXEC_BUS_WIDTH-1:0] exec_bus,
  output logic [MEM_BUS_WIDTH-1:0]  mem_bus,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus,
  output logic                      reads_rs,
  output logic                      reads_rt,
  output logic                      is_halt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] alu_op;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    exec_bus = '0;
    mem_bus  = '0;
    wb_bus   = '0;
    alu_op   = 4'd0;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    is_halt  = 1'b0;

    if (opcode == OP_RTYPE) begin
      reads_rt             = 1'b1;
      exec_bus[EX_REG_DST] = 1'b1;
      wb_bus[WB_REGWRITE]  = 1'b1;
      case (funct)
        FN_SLL:          begin alu_op = ALU_SLL; exec_bus[EX_SHAMT] = 1'b1; end
        FN_SRL:          begin alu_op = ALU_SRL; exec_bus[EX_SHAMT] = 1'b1; end
        FN_SRA:          begin alu_op = ALU_SRA; exec_bus[EX_SHAMT] = 1'b1; end
        FN_SLLV:         alu_op = ALU_SLL;
        FN_SRLV:         alu_op = ALU_SRL;
        FN_SRAV:         alu_op = ALU_SRA;
        FN_ADD, FN_ADDU: alu_op = ALU_ADD;
        FN_SUBU:         alu_op = ALU_SUB;
        FN_AND:          alu_op = ALU_AND;
        FN_OR:           alu_op = ALU_OR;
        FN_XOR:          alu_op = ALU_XOR;
        FN_NOR:          alu_op = ALU_NOR;
        FN_SLT:          alu_op = ALU_SLT;
        default:         alu_op = ALU_INVALID;
      endcase
      // jr/jalr and the all-zero NOP must not write the register file
      if (funct == FN_JR || funct == FN_JALR || instr == 32'h0)
        wb_bus[WB_REGWRITE] = 1'b0;
    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
      reads_rt            = 1'b1;
      alu_op              = ALU_SUB;
      mem_bus[MEM_BRANCH] = 1'b1;
    end else if (opcode == OP_J || opcode == OP_JAL) begin
      reads_rs            = 1'b0;
      alu_op              = ALU_INVALID;
      mem_bus[MEM_BRANCH] = 1'b1;
    end else if (opcode[5:4] == 2'b10) begin
      alu_op               = ALU_ADD;
      exec_bus[EX_ALU_SRC] = 1'b1;
      if (opcode[3]) begin
        reads_rt           = 1'b1;
        mem_bus[MEM_WRITE] = 1'b1;
      end else begin
        mem_bus[MEM_READ]   = 1'b1;
        wb_bus[WB_MEM2REG]  = 1'b1;
        wb_bus[WB_REGWRITE] = 1'b1;
      end
    end else if (opcode[5:3] == 3'b001) begin
      exec_bus[EX_ALU_SRC] = 1'b1;
      wb_bus[WB_REGWRITE]  = 1'b1;
      case (opcode)
        OP_ADDI: alu_op = ALU_ADD;
        OP_ANDI: alu_op = ALU_AND;
        OP_ORI:  alu_op = ALU_OR;
        OP_XORI: alu_op = ALU_XOR;
        OP_LUI:  alu_op = ALU_SLL;
        OP_SLTI: alu_op = ALU_SLT;
        default: alu_op = ALU_INVALID;
      endcase
    end else if (opcode == OP_HALT) begin
      reads_rs = 1'b0;
      is_halt  = 1'b1;
    end

    exec_bus[3:0] = alu_op;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control slice: decode, load-use stall, flush bubbles, HALT drain FSM; 1-cycle latency.
// Backpressure: o_stall (combinational) holds PC and IF/ID on load-use and after HALT.
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DRAIN_CYCLES   = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               i_instr,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
  output logic [EXEC_BUS_WIDTH-1:0] o_exec_bus,
  output logic [MEM_BUS_WIDTH-1:0]  o_mem_bus,
  output logic [WB_BUS_WIDTH-1:0]   o_wb_bus,
  output logic [REG_ADDR_WIDTH-1:0] o_rs,
  output logic [REG_ADDR_WIDTH-1:0] o_rt,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic                      o_valid,
  output logic                      o_stall,
  output logic                      o_halted,
  output logic [CNT_WIDTH-1:0]      o_stall_count
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  logic [EXEC_BUS_WIDTH-1:0] dec_exec;
  logic [MEM_BUS_WIDTH-1:0]  dec_mem;
  logic [WB_BUS_WIDTH-1:0]   dec_wb;
  logic                      dec_reads_rs;
  logic                      dec_reads_rt;
  logic                      dec_is_halt;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      hazard;

  state_e                    state_q, state_d;
  logic [3:0]                drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
  logic [EXEC_BUS_WIDTH-1:0] exec_q, exec_d;
  logic [MEM_BUS_WIDTH-1:0]  mem_q, mem_d;
  logic [WB_BUS_WIDTH-1:0]   wb_q, wb_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
  logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      valid_q, valid_d;

  ctrl_decode #(
    .EXEC_BUS_WIDTH(EXEC_BUS_WIDTH),
    .MEM_BUS_WIDTH (MEM_BUS_WIDTH),
    .WB_BUS_WIDTH  (WB_BUS_WIDTH)
  ) u_decode (
    .instr   (i_instr),
    .exec_bus(dec_exec),
    .mem_bus (dec_mem),
    .wb_bus  (dec_wb),
    .reads_rs(dec_reads_rs),
    .reads_rt(dec_reads_rt),
    .is_halt (dec_is_halt)
  );

  assign rs = i_instr[25:21];
  assign rt = i_instr[20:16];
  assign rd = i_instr[15:11];

  assign hazard = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                  ((dec_reads_rs && (i_ex_rt == rs)) || (dec_reads_rt && (i_ex_rt == rt)));

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    exec_d      = '0;
    mem_d       = '0;
    wb_d        = '0;
    rs_d        = '0;
    rt_d        = '0;
    rd_d        = '0;
    valid_d     = 1'b0;
    o_stall     = 1'b0;

    // The drain countdown runs regardless of what sits in ID
    if (state_q == ST_DRAIN) begin
      if (drain_cnt_q == 4'd0) state_d = ST_HALTED;
      else                     drain_cnt_d = drain_cnt_q - 4'd1;
    end

    if (reset || i_flush) begin
      o_stall = 1'b0;
    end else if (state_q != ST_RUN) begin
      o_stall = 1'b1;
    end else if (hazard) begin
      o_stall = 1'b1;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (i_valid && dec_is_halt) begin
      state_d     = ST_DRAIN;
      drain_cnt_d = DRAIN_INIT;
    end else if (i_valid) begin
      exec_d  = dec_exec;
      mem_d   = dec_mem;
      wb_d    = dec_wb;
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      exec_q      <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      exec_q      <= exec_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
    end
  end

  assign o_exec_bus    = exec_q;
  assign o_mem_bus     = mem_q;
  assign o_wb_bus      = wb_q;
  assign o_rs          = rs_q;
  assign o_rt          = rt_q;
  assign o_rd          = rd_q;
  assign o_valid       = valid_q;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode table, load-use stall, flush, HALT drain, counter saturation.
module tb_id_ctrl_stage;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8CA40000;
  localparam logic [31:0] I_HALT = 32'hFC000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_instr;
  logic        i_valid, i_flush, i_ex_mem_read;
  logic [4:0]  i_ex_rt;

  logic [6:0]  o_exec_bus;
  logic [2:0]  o_mem_bus;
  logic [1:0]  o_wb_bus;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_valid, o_stall, o_halted;
  logic [15:0] o_stall_count;

  logic [6:0]  d4_exec_bus;
  logic [2:0]  d4_mem_bus;
  logic [1:0]  d4_wb_bus;
  logic [4:0]  d4_rs, d4_rt, d4_rd;
  logic        d4_valid, d4_stall, d4_halted;
  logic [3:0]  d4_stall_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ctrl_stage u_dut (
    .clk(clk), .reset(reset), .i_instr(i_instr), .i_valid(i_valid), .i_flush(i_flush),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_exec_bus(o_exec_bus), .o_mem_bus(o_mem_bus), .o_wb_bus(o_wb_bus),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_valid(o_valid), .o_stall(o_stall),
    .o_halted(o_halted), .o_stall_count(o_stall_count)
  );

  id_ctrl_stage #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .i_instr(i_instr), .i_valid(i_valid), .i_flush(i_flush),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_exec_bus(d4_exec_bus), .o_mem_bus(d4_mem_bus), .o_wb_bus(d4_wb_bus),
    .o_rs(d4_rs), .o_rt(d4_rt), .o_rd(d4_rd), .o_valid(d4_valid), .o_stall(d4_stall),
    .o_halted(d4_halted), .o_stall_count(d4_stall_count)
  );

  // instruction, valid, expected {exec, mem, wb, valid}
  logic [31:0] dec_ins [16] = '{
    32'h00221820, 32'h8CA40000, 32'hACA40004, 32'h10220003,
    32'h08000010, 32'h34220005, 32'h00011100, 32'h03E00008,
    32'h00221827, 32'h00000000, 32'hF8000000, 32'h00221820,
    32'h3C010001, 32'h24220001, 32'h00221823, 32'h00221822};
  logic        dec_vld [16] = '{1,1,1,1, 1,1,1,1, 1,1,1,0, 1,1,1,1};
  logic [12:0] dec_exp [16] = '{
    {7'b0100011, 3'b000, 2'b10, 1'b1}, {7'b0010011, 3'b010, 2'b11, 1'b1},
    {7'b0010011, 3'b001, 2'b00, 1'b1}, {7'b0001000, 3'b100, 2'b00, 1'b1},
    {7'b0001111, 3'b100, 2'b00, 1'b1}, {7'b0010101, 3'b000, 2'b10, 1'b1},
    {7'b1100000, 3'b000, 2'b10, 1'b1}, {7'b0101111, 3'b000, 2'b00, 1'b1},
    {7'b0100111, 3'b000, 2'b10, 1'b1}, {7'b1100000, 3'b000, 2'b00, 1'b1},
    {7'b0000000, 3'b000, 2'b00, 1'b1}, {7'b0000000, 3'b000, 2'b00, 1'b0},
    {7'b0010000, 3'b000, 2'b10, 1'b1}, {7'b0011111, 3'b000, 2'b10, 1'b1},
    {7'b0101000, 3'b000, 2'b10, 1'b1}, {7'b0101111, 3'b000, 2'b10, 1'b1}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic fl,
                       input logic emr, input logic [4:0] ert);
    i_instr       = ins;
    i_valid       = vld;
    i_flush       = fl;
    i_ex_mem_read = emr;
    i_ex_rt       = ert;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(I_ADD, 1'b1, 1'b0, 1'b1, 5'd2);
    step();
    step();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", o_stall); end
    checks++; if ({o_exec_bus, o_mem_bus, o_wb_bus, o_valid} !== 13'd0) begin errors++;
      $display("FAIL reset_buses got %h want 0", {o_exec_bus, o_mem_bus, o_wb_bus, o_valid}); end
    checks++; if ({o_rs, o_rt, o_rd} !== 15'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {o_rs, o_rt, o_rd}); end
    checks++; if (o_halted !== 1'b0 || o_stall_count !== 16'd0) begin errors++;
      $display("FAIL reset_halt_cnt got halted=%0b cnt=%0d want 0/0", o_halted, o_stall_count); end
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    exp_cnt = 0;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 16; i++) begin
      drive(dec_ins[i], dec_vld[i], 1'b0, 1'b0, 5'd0);
      step();
      checks++;
      if ({o_exec_bus, o_mem_bus, o_wb_bus, o_valid} !== dec_exp[i]) begin
        errors++;
        $display("FAIL decode_%0d instr=%h got %b want %b", i, dec_ins[i],
                 {o_exec_bus, o_mem_bus, o_wb_bus, o_valid}, dec_exp[i]);
      end
      if (i == 0) begin
        checks++;
        if ({o_rs, o_rt, o_rd} !== {5'd1, 5'd2, 5'd3}) begin errors++;
          $display("FAIL decode_fields got rs=%0d rt=%0d rd=%0d want 1/2/3", o_rs, o_rt, o_rd); end
      end
    end
  endtask

  task automatic test_hazard();
    drive(I_ADD, 1'b1, 1'b0, 1'b1, 5'd2);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL hazard_rt_stall got %0b want 1", o_stall); end
    step();
    exp_cnt++;
    checks++; if ({o_exec_bus, o_valid} !== 8'd0) begin errors++; $display("FAIL hazard_bubble got %h want 0", {o_exec_bus, o_valid}); end
    checks++; if (o_stall_count !== 16'(exp_cnt)) begin errors++; $display("FAIL hazard_cnt got %0d want %0d", o_stall_count, exp_cnt); end

    drive(I_ADD, 1'b1, 1'b0, 1'b1, 5'd0);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hazard_r0_stall got %0b want 0", o_stall); end
    step();
    checks++; if (o_valid !== 1'b1 || o_stall_count !== 16'(exp_cnt)) begin errors++;
      $display("FAIL hazard_r0_pass got valid=%0b cnt=%0d want 1/%0d", o_valid, o_stall_count, exp_cnt); end

    drive(I_LW, 1'b1, 1'b0, 1'b1, 5'd4);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hazard_lw_rt_unread got %0b want 0", o_stall); end
    drive(I_ADD, 1'b0, 1'b0, 1'b1, 5'd2);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hazard_invalid got %0b want 0", o_stall); end
    drive(I_LW, 1'b1, 1'b0, 1'b1, 5'd5);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL hazard_lw_rs got %0b want 1", o_stall); end
    step();
    exp_cnt++;
    checks++; if (o_stall_count !== 16'(exp_cnt)) begin errors++; $display("FAIL hazard_cnt2 got %0d want %0d", o_stall_count, exp_cnt); end
  endtask

  task automatic test_flush();
    drive(I_ADD, 1'b1, 1'b1, 1'b1, 5'd2);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", o_stall); end
    step();
    checks++; if ({o_exec_bus, o_mem_bus, o_wb_bus, o_valid} !== 13'd0) begin errors++;
      $display("FAIL flush_bubble got %h want 0", {o_exec_bus, o_mem_bus, o_wb_bus, o_valid}); end
    checks++; if (o_stall_count !== 16'(exp_cnt)) begin errors++; $display("FAIL flush_cnt got %0d want %0d", o_stall_count, exp_cnt); end
  endtask

  task automatic test_saturate();
    drive(I_ADD, 1'b1, 1'b0, 1'b1, 5'd2);
    repeat (18) step();
    exp_cnt += 18;
    checks++; if (d4_stall_count !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d want 15", d4_stall_count); end
    checks++; if (o_stall_count !== 16'(exp_cnt)) begin errors++; $display("FAIL sat_cnt16 got %0d want %0d", o_stall_count, exp_cnt); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
  endtask

  task automatic test_halt_flush();
    drive(I_HALT, 1'b1, 1'b1, 1'b0, 5'd0);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hflush_stall got %0b want 0", o_stall); end
    step();
    drive(I_LW, 1'b1, 1'b0, 1'b0, 5'd0);
    checks++; if (o_stall !== 1'b0 || o_halted !== 1'b0) begin errors++;
      $display("FAIL hflush_run got stall=%0b halted=%0b want 0/0", o_stall, o_halted); end
    step();
    checks++; if ({o_exec_bus, o_mem_bus, o_wb_bus, o_valid} !== {7'b0010011, 3'b010, 2'b11, 1'b1}) begin errors++;
      $display("FAIL hflush_lw got %b want 0010011010111", {o_exec_bus, o_mem_bus, o_wb_bus, o_valid}); end
  endtask

  task automatic test_halt();
    drive(I_HALT, 1'b1, 1'b0, 1'b0, 5'd0);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL halt_pre_stall got %0b want 0", o_stall); end
    step();
    drive(I_ADD, 1'b1, 1'b0, 1'b0, 5'd0);
    checks++; if (o_stall !== 1'b1 || o_valid !== 1'b0 || o_halted !== 1'b0) begin errors++;
      $display("FAIL halt_e0 got stall=%0b valid=%0b halted=%0b want 1/0/0", o_stall, o_valid, o_halted); end
    step();
    checks++; if (o_halted !== 1'b0 || o_valid !== 1'b0) begin errors++;
      $display("FAIL halt_e1 got halted=%0b valid=%0b want 0/0", o_halted, o_valid); end
    step();
    checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_e2 got %0b want 0", o_halted); end
    step();
    checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_e3 got %0b want 1", o_halted); end
    repeat (3) step();
    checks++; if (o_halted !== 1'b1 || o_stall !== 1'b1 || o_valid !== 1'b0) begin errors++;
      $display("FAIL halt_hold got halted=%0b stall=%0b valid=%0b want 1/1/0", o_halted, o_stall, o_valid); end
    reset = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL halt_reset_stall got %0b want 0", o_stall); end
    step();
    checks++; if (o_halted !== 1'b0 || o_stall_count !== 16'd0) begin errors++;
      $display("FAIL halt_reset got halted=%0b cnt=%0d want 0/0", o_halted, o_stall_count); end
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    checks++; if (o_stall !== 1'b0 || o_halted !== 1'b0) begin errors++;
      $display("FAIL halt_after_reset got stall=%0b halted=%0b want 0/0", o_stall, o_halted); end
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_decode();
    test_hazard();
    test_flush();
    test_saturate();
    test_halt_flush();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
